// File: rtl/oscill_trig_ctrl.sv
// Oscilloscope trigger controller: level/hysteresis edge detection with
// pre-trigger fill, holdoff, auto-trigger timeout and single-shot mode.
module oscill_trig_ctrl #(
    parameter int unsigned DW          = 8,
    parameter int unsigned CW          = 16,
    parameter int unsigned PRE_SAMPLES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] level,
    input  logic [DW-1:0] hyst,
    input  logic [1:0]    mode,
    input  logic          run,
    input  logic          single,
    input  logic [CW-1:0] holdoff,
    input  logic          auto_en,
    input  logic [CW-1:0] auto_timeout,
    output logic          trig,
    output logic          trig_auto,
    output logic          armed,
    output logic          busy,
    output logic [CW-1:0] trig_cnt
);

    localparam int unsigned PW = (PRE_SAMPLES < 2) ? 1 : $clog2(PRE_SAMPLES);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE_SAMPLES - 1);
    localparam logic [DW:0]   DIN_MAX  = {1'b0, {DW{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pre_cnt, pre_cnt_n;
    logic [CW-1:0] auto_cnt, auto_cnt_n;
    logic [CW-1:0] hold_cnt, hold_cnt_n;
    logic          lo_arm, lo_arm_n;
    logic          hi_arm, hi_arm_n;
    logic          single_q, single_q_n;
    logic          done_q, done_q_n;
    logic          trig_n, trig_auto_n, armed_n, busy_n;
    logic [CW-1:0] trig_cnt_n;

    logic [DW:0]   hi_sum_c;
    logic [DW-1:0] lo_th_c, hi_th_c;
    logic          rise_hit_c, fall_hit_c, hit_c;
    logic [CW-1:0] auto_last_c, hold_last_c;
    logic          auto_fire_c;

    // Hysteresis thresholds, saturated to the sample range
    always_comb begin
        hi_sum_c = {1'b0, level} + {1'b0, hyst};
        lo_th_c  = (level >= hyst) ? DW'(level - hyst) : '0;
        hi_th_c  = (hi_sum_c > DIN_MAX) ? DIN_MAX[DW-1:0] : hi_sum_c[DW-1:0];
    end

    // Edge hit qualification using the flags as they stood before this sample
    always_comb begin
        rise_hit_c = din_valid && (din >= level) && lo_arm;
        fall_hit_c = din_valid && (din <= level) && hi_arm;
        unique case (mode)
            2'b01:   hit_c = fall_hit_c;
            2'b10:   hit_c = rise_hit_c || fall_hit_c;
            default: hit_c = rise_hit_c;
        endcase
    end

    // Terminal counts; zero-valued settings behave as one
    always_comb begin
        auto_last_c = (auto_timeout == '0) ? '0 : CW'(auto_timeout - CW'(1));
        hold_last_c = (holdoff == '0) ? '0 : CW'(holdoff - CW'(1));
        auto_fire_c = auto_en && (auto_cnt == auto_last_c);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n     = state;
        pre_cnt_n   = pre_cnt;
        auto_cnt_n  = auto_cnt;
        hold_cnt_n  = hold_cnt;
        lo_arm_n    = lo_arm;
        hi_arm_n    = hi_arm;
        single_q_n  = single_q;
        done_q_n    = done_q;
        trig_n      = 1'b0;
        trig_auto_n = 1'b0;

        if (!run) begin
            state_n    = S_IDLE;
            pre_cnt_n  = '0;
            auto_cnt_n = '0;
            hold_cnt_n = '0;
            lo_arm_n   = 1'b0;
            hi_arm_n   = 1'b0;
            single_q_n = 1'b0;
            done_q_n   = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // A finished single shot stays parked until run is dropped
                    if (!done_q) begin
                        state_n    = S_PRE;
                        single_q_n = single;
                        pre_cnt_n  = '0;
                    end
                end
                S_PRE: begin
                    if (din_valid) begin
                        if (pre_cnt == PRE_LAST) begin
                            state_n    = S_WAIT;
                            pre_cnt_n  = '0;
                            auto_cnt_n = '0;
                            lo_arm_n   = 1'b0;
                            hi_arm_n   = 1'b0;
                        end else begin
                            pre_cnt_n = pre_cnt + PW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    auto_cnt_n = auto_cnt + CW'(1);
                    if (din_valid && (din < lo_th_c)) begin
                        lo_arm_n = 1'b1;
                    end
                    if (din_valid && (din > hi_th_c)) begin
                        hi_arm_n = 1'b1;
                    end
                    if (hit_c || auto_fire_c) begin
                        trig_n      = 1'b1;
                        trig_auto_n = !hit_c;
                        state_n     = S_HOLD;
                        hold_cnt_n  = '0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == hold_last_c) begin
                        hold_cnt_n = '0;
                        if (single_q) begin
                            state_n  = S_IDLE;
                            done_q_n = 1'b1;
                        end else begin
                            state_n   = S_PRE;
                            pre_cnt_n = '0;
                        end
                    end else begin
                        hold_cnt_n = hold_cnt + CW'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        trig_cnt_n = trig_cnt + CW'(trig_n);
        armed_n    = (state_n == S_WAIT);
        busy_n     = (state_n != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pre_cnt   <= '0;
            auto_cnt  <= '0;
            hold_cnt  <= '0;
            lo_arm    <= 1'b0;
            hi_arm    <= 1'b0;
            single_q  <= 1'b0;
            done_q    <= 1'b0;
            trig      <= 1'b0;
            trig_auto <= 1'b0;
            armed     <= 1'b0;
            busy      <= 1'b0;
            trig_cnt  <= '0;
        end else begin
            state     <= state_n;
            pre_cnt   <= pre_cnt_n;
            auto_cnt  <= auto_cnt_n;
            hold_cnt  <= hold_cnt_n;
            lo_arm    <= lo_arm_n;
            hi_arm    <= hi_arm_n;
            single_q  <= single_q_n;
            done_q    <= done_q_n;
            trig      <= trig_n;
            trig_auto <= trig_auto_n;
            armed     <= armed_n;
            busy      <= busy_n;
            trig_cnt  <= trig_cnt_n;
        end
    end

endmodule

// File: tb/tb_oscill_trig_ctrl.sv
// Scoreboard bench for oscill_trig_ctrl: stimulus pushes expected triggers,
// a negedge monitor pops and compares every trig pulse the DUT presents.
module tb_oscill_trig_ctrl;

    localparam int unsigned DW  = 8;
    localparam int unsigned CW  = 16;
    localparam int unsigned PRE = 4;

    logic          clk;
    logic          rst_n;
    logic          din_valid;
    logic [DW-1:0] din;
    logic [DW-1:0] level;
    logic [DW-1:0] hyst;
    logic [1:0]    mode;
    logic          run;
    logic          single;
    logic [CW-1:0] holdoff;
    logic          auto_en;
    logic [CW-1:0] auto_timeout;
    logic          trig;
    logic          trig_auto;
    logic          armed;
    logic          busy;
    logic [CW-1:0] trig_cnt;

    typedef struct packed {
        logic [31:0]   cyc;
        logic          aut;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    oscill_trig_ctrl #(
        .DW          (DW),
        .CW          (CW),
        .PRE_SAMPLES (PRE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_valid    (din_valid),
        .din          (din),
        .level        (level),
        .hyst         (hyst),
        .mode         (mode),
        .run          (run),
        .single       (single),
        .holdoff      (holdoff),
        .auto_en      (auto_en),
        .auto_timeout (auto_timeout),
        .trig         (trig),
        .trig_auto    (trig_auto),
        .armed        (armed),
        .busy         (busy),
        .trig_cnt     (trig_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one valid sample in the cycle starting at this negedge
    task automatic drive(input logic [DW-1:0] d);
        @(negedge clk);
        din_valid = 1'b1;
        din       = d;
    endtask

    // Trigger expected at the edge that registers the sample just driven
    task automatic expect_trig(input logic aut, input logic [CW-1:0] cnt);
        exp_t e;
        e.cyc = 32'(cyc + 1);
        e.aut = aut;
        e.cnt = cnt;
        q.push_back(e);
    endtask

    // Raise run and feed PRE fill samples; next drive lands in WAIT
    task automatic start(input logic [DW-1:0] pre_val);
        @(negedge clk);
        run       = 1'b1;
        din_valid = 1'b0;
        for (int i = 0; i < int'(PRE); i++) drive(pre_val);
    endtask

    task automatic stop();
        @(negedge clk);
        run       = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("armed_after_stop", 32'(armed), 32'd0);
    endtask

    initial begin
        cyc          = 0;
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        din_valid    = 1'b0;
        din          = '0;
        level        = 8'h80;
        hyst         = 8'h00;
        mode         = 2'b00;
        run          = 1'b0;
        single       = 1'b0;
        holdoff      = '0;
        auto_en      = 1'b0;
        auto_timeout = '0;

        repeat (3) @(negedge clk);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_trig_auto", 32'(trig_auto), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trig_cnt", 32'(trig_cnt), 32'd0);
        rst_n = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (trig === 1'b1) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_trig: got trig=1 cnt=%0d expected none (cyc %0d)",
                                 trig_cnt, cyc);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("trig_cycle", 32'(cyc), e.cyc);
                        chk("trig_auto", 32'(trig_auto), 32'(e.aut));
                        chk("trig_cnt", 32'(trig_cnt), 32'(e.cnt));
                    end
                end else begin
                    chk("trig_auto_idle", 32'(trig_auto), 32'd0);
                end
            end
        join_none

        // 1: plain rising crossing, hyst 0
        start(8'h00);
        drive(8'h70);
        chk("t1_armed", 32'(armed), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        drive(8'h90);
        expect_trig(1'b0, 16'd1);
        stop();

        // 2: hysteresis, only a sample below 0x70 arms the rising edge
        hyst = 8'h10;
        start(8'h00);
        drive(8'h78);
        drive(8'h82);
        drive(8'h75);
        drive(8'h85);
        drive(8'h6F);
        drive(8'h81);
        expect_trig(1'b0, 16'd2);
        stop();

        // 3: either-edge square wave with holdoff 5, period 11 samples
        hyst    = 8'h00;
        mode    = 2'b10;
        level   = 8'h40;
        holdoff = 16'd5;
        @(negedge clk);
        run       = 1'b1;
        din_valid = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            drive(k[0] ? 8'h7F : 8'h00);
            if (k == 5)  expect_trig(1'b0, 16'd3);
            if (k == 16) expect_trig(1'b0, 16'd4);
            if (k == 27) expect_trig(1'b0, 16'd5);
            if (k == 38) expect_trig(1'b0, 16'd6);
        end
        stop();

        // 4: auto trigger after 100 WAIT cycles, repeating
        mode         = 2'b00;
        level        = 8'h80;
        holdoff      = 16'd2;
        auto_en      = 1'b1;
        auto_timeout = 16'd100;
        start(8'h10);
        for (int k = 4; k <= 212; k++) begin
            drive(8'h10);
            if (k == 4)   chk("t4_armed_rise", 32'(armed), 32'd1);
            if (k == 103) expect_trig(1'b1, 16'd7);
            if (k == 104) chk("t4_armed_hold", 32'(armed), 32'd0);
            if (k == 209) expect_trig(1'b1, 16'd8);
        end
        stop();

        // 4b: auto_timeout 0 fires on the first WAIT cycle
        auto_timeout = 16'd0;
        start(8'h10);
        drive(8'h10);
        expect_trig(1'b1, 16'd9);
        stop();

        // 4c: hit and auto timeout together give one non-auto trig
        auto_timeout = 16'd2;
        start(8'h10);
        drive(8'h10);
        drive(8'h90);
        expect_trig(1'b0, 16'd10);
        stop();

        // 5: single-shot falling trigger, parked until run toggles
        auto_en = 1'b0;
        holdoff = 16'd0;
        single  = 1'b1;
        mode    = 2'b01;
        start(8'h00);
        drive(8'h90);
        drive(8'h70);
        expect_trig(1'b0, 16'd11);
        drive(8'h90);
        for (int k = 0; k < 6; k++) begin
            drive(k[0] ? 8'h90 : 8'h70);
            chk("t5_busy_parked", 32'(busy), 32'd0);
        end
        stop();
        start(8'h00);
        drive(8'h90);
        drive(8'h70);
        expect_trig(1'b0, 16'd12);
        stop();

        // 6a: run dropped together with a hit suppresses the trig
        single = 1'b0;
        mode   = 2'b00;
        start(8'h00);
        drive(8'h70);
        @(negedge clk);
        run       = 1'b0;
        din_valid = 1'b1;
        din       = 8'h90;
        @(negedge clk);
        din_valid = 1'b0;
        chk("t6_busy_run_wins", 32'(busy), 32'd0);
        chk("t6_trig_run_wins", 32'(trig), 32'd0);

        // 6b: asynchronous reset in HOLD
        holdoff = 16'd5;
        start(8'h00);
        drive(8'h70);
        drive(8'h90);
        expect_trig(1'b0, 16'd13);
        @(negedge clk);
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_trig_cnt", 32'(trig_cnt), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_armed", 32'(armed), 32'd0);
        chk("t6_rst_trig", 32'(trig), 32'd0);
        chk("t6_rst_trig_auto", 32'(trig_auto), 32'd0);
        @(negedge clk);
        run   = 1'b0;
        rst_n = 1'b1;

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oscill_trig_ctrl.md
Name: oscill_trig_ctrl

Overview:
Parametrised oscilloscope trigger controller, the next generation of the single-edge trigger selector. It operates on a single-clock sample stream downstream of the ADC CDC FIFO. Features:
- rising, falling or either-edge detection against a programmable level, with hysteresis for noise rejection
- pre-trigger fill count, holdoff, auto-trigger timeout and single-shot mode
- 1-cycle trigger pulse that drives the capture buffer write-stop logic

Parameters:
DW, 8, sample/level/hysteresis width
CW, 16, holdoff and auto-timeout counter width
PRE_SAMPLES, 16, valid samples accepted after arming before trigger detection is enabled (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  reset; asynchronous, active-low
din_valid  in  1  din carries a new sample this cycle
din  in  DW  unsigned sample
level  in  DW  unsigned trigger level
hyst  in  DW  hysteresis band
mode  in  2  00 rising, 01 falling, 10 either, 11 treated as rising
run  in  1  1 = acquisition enabled
single  in  1  sampled on IDLE->PRE transition; 1 = stop after one trigger
holdoff  in  CW  clk cycles in HOLD after a trigger (0 = one cycle)
auto_en  in  1  enable auto-trigger
auto_timeout  in  CW  clk cycles in WAIT before forced trigger
trig  out  1  1-cycle trigger pulse
trig_auto  out  1  qualifies trig: 1 = forced by timeout
armed  out  1  high while in WAIT
busy  out  1  high in any state except IDLE
trig_cnt  out  CW  triggers since reset, wraps at 2^CW

Behaviour:
- Reset: state IDLE; trig, trig_auto, armed, busy = 0; trig_cnt = 0; all counters and flags = 0.
- Thresholds are computed in DW+1 bits:
  - lo_th = max(level - hyst, 0)
  - hi_th = min(level + hyst, 2^DW - 1)
- Edge flags update only on din_valid, and only in WAIT:
  - lo_arm is set when din < lo_th.
  - hi_arm is set when din > hi_th.
  - Both flags clear when WAIT is entered.
- Rising hit: din_valid && din >= level && lo_arm (flag value before the current sample).
- Falling hit: din_valid && din <= level && hi_arm.
- Either mode: rising hit OR falling hit.
- With hyst = 0 this reduces to a plain crossing: previous sample < level and current >= level (rising).
- States:
  - IDLE: when run=1, go to PRE and latch single into single_q.
  - PRE: count din_valid samples; after PRE_SAMPLES of them, go to WAIT and clear the auto counter.
  - WAIT: a hit sets trig=1 and trig_auto=0 on the next clock edge (1-cycle registered latency), then go to HOLD. Otherwise, if auto_en and the auto counter == auto_timeout-1, set trig=1 and trig_auto=1, then go to HOLD. The auto counter increments every clk while in WAIT.
  - HOLD: count clk cycles up to max(holdoff,1). Then go to IDLE if single_q=1, else to PRE.
- trig_cnt increments on every trig, forced triggers included.
- trig_auto is valid only when trig=1, and is 0 otherwise.
- run=0 in any state: go to IDLE on the next edge and clear counters and flags. If run=0 and a hit occur in the same cycle, run wins and no trig is issued.
- A hit and auto timeout in the same cycle produce one trig with trig_auto=0.
- auto_timeout = 0 with auto_en=1 is treated as 1.
- Changes to level, hyst or mode take effect on the next sample. Edge flags are not cleared by such a change.
- Samples arriving in PRE and HOLD never produce hits and never set the flags.
- Asserting rst_n low mid-operation returns everything to reset values immediately.

Test Plan:
1. DW=8, level=0x80, hyst=0, mode=00. After PRE, stream 0x70,0x90 -> trig one cycle after 0x90; trig_auto=0; trig_cnt=1.
2. level=0x80, hyst=0x10, mode=00. Stream 0x78,0x82,0x75,0x85, then 0x6F,0x81 -> no trig until 0x81 (only 0x6F < 0x70 arms lo_arm); exactly one trig.
3. mode=10, level=0x40, holdoff=5, single=0. Stream a square wave 0x00/0x7F every valid cycle -> trigs separated by >= 5 HOLD cycles plus PRE_SAMPLES; both edges trigger.
4. auto_en=1, auto_timeout=100, constant din=0x10, level=0x80 -> trig with trig_auto=1 exactly 100 clk cycles after armed rises; repeats each cycle of PRE+WAIT+HOLD.
5. single=1, mode=01, level=0x80 -> one falling trig, then busy=0 and state IDLE; further crossings give no trig until run toggles 0->1.
6. Deassert run in the same cycle as a hit -> no trig, busy=0 on the next edge. Assert rst_n=0 mid-HOLD -> trig_cnt=0 and all outputs 0 asynchronously.
